// File: rtl/mdu_iterative.sv
// mdu_iterative: multi-cycle multiply/divide unit that owns the HI/LO registers.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division.
// Each operation takes WIDTH iterations, plus one cycle to apply signs.
// Optional macro MDU_FAST_ZERO_EN: trivial zero operands skip the iteration phase.
module mdu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               state, stateNext;
  logic                 isDiv, sa, sb, divZero;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     quot;
  logic [CW-1:0]        count;

  logic                 signedOp, aNeg, bNeg, fastZero;
  logic [WIDTH-1:0]     aMag, bMag;
  logic [WIDTH:0]       mulSum, divShift, divDiff;
  logic [2*WIDTH-1:0]   prodRes;
  logic [WIDTH-1:0]     quotRes, remRes;

  // Operand magnitudes: signed ops strip the sign, unsigned ops pass through
  always_comb begin
    signedOp = ~op[0];
    aNeg     = signedOp & a[WIDTH-1];
    bNeg     = signedOp & b[WIDTH-1];
    aMag     = aNeg ? -a : a;
    bMag     = bNeg ? -b : b;
  end

`ifdef MDU_FAST_ZERO_EN
  assign fastZero = op[1] ? (b == '0) : ((a == '0) || (b == '0));
`else
  assign fastZero = 1'b0;
`endif

  // One iteration step of each algorithm plus the sign-corrected final results
  always_comb begin
    mulSum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mcand : '0)};
    divShift = {rem, quot[WIDTH-1]};
    divDiff  = divShift - {1'b0, mcand};
    prodRes  = (sa ^ sb) ? -prod : prod;
    quotRes  = divZero ? '1 : ((sa ^ sb) ? -quot : quot);
    remRes   = sa ? -rem : rem;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state: IDLE -> CALC (or straight to FIX on a fast zero) -> FIX -> IDLE
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (start) stateNext = fastZero ? FIX : CALC;
      CALC: if (count == CW'(1)) stateNext = FIX;
      FIX:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Datapath: latch operands, iterate, then commit signed results to HI/LO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      isDiv   <= 1'b0;
      sa      <= 1'b0;
      sb      <= 1'b0;
      divZero <= 1'b0;
      mcand   <= '0;
      prod    <= '0;
      rem     <= '0;
      quot    <= '0;
      count   <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            isDiv   <= op[1];
            sa      <= aNeg;
            sb      <= bNeg;
            divZero <= (b == '0);
            mcand   <= op[1] ? bMag : aMag;
            prod    <= fastZero ? '0 : {{WIDTH{1'b0}}, bMag};
            rem     <= fastZero ? aMag : '0;
            quot    <= aMag;
            count   <= CW'(WIDTH);
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          count <= count - CW'(1);
          if (isDiv) begin
            if (!divDiff[WIDTH]) begin
              rem  <= divDiff[WIDTH-1:0];
              quot <= {quot[WIDTH-2:0], 1'b1};
            end else begin
              rem  <= divShift[WIDTH-1:0];
              quot <= {quot[WIDTH-2:0], 1'b0};
            end
          end else begin
            prod <= {mulSum, prod[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (isDiv) begin
            hi <= remRes;
            lo <= quotRes;
          end else begin
            hi <= prodRes[2*WIDTH-1:WIDTH];
            lo <= prodRes[WIDTH-1:0];
          end
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: self-checking bench for mdu_iterative.
// Directed and random MULT/MULTU/DIV/DIVU checked against an arithmetic model.
// Honours MDU_FAST_ZERO_EN for expected latency.
module tb_mdu_iterative;

  localparam int WIDTH = 32;

  logic        clk = 1'b0;
  logic        rst, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int passes = 0;
  logic [31:0] modelHi = '0;
  logic [31:0] modelLo = '0;

  mdu_iterative #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference results straight from the arithmetic definitions
  function automatic void refModel(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] rh, output logic [31:0] rl);
    longint      sp, sq, sr;
    logic [63:0] up;
    case (o)
      2'b00: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        rh = sp[63:32]; rl = sp[31:0];
      end
      2'b01: begin
        up = {32'b0, x} * {32'b0, y};
        rh = up[63:32]; rl = up[31:0];
      end
      default: begin
        if (y == 32'd0) begin
          rl = 32'hFFFF_FFFF; rh = x;
        end else if (o == 2'b10) begin
          sq = longint'($signed(x)) / longint'($signed(y));
          sr = longint'($signed(x)) % longint'($signed(y));
          rl = sq[31:0]; rh = sr[31:0];
        end else begin
          rl = x / y; rh = x % y;
        end
      end
    endcase
  endfunction

  function automatic int expLat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
`ifdef MDU_FAST_ZERO_EN
    if ((o[1] && y == 32'd0) || (!o[1] && (x == 32'd0 || y == 32'd0))) return 2;
`endif
    if (o == 2'b11 && x == 32'hFFFF_FFFF && y == 32'hFFFF_FFFF) return WIDTH + 2;
    return WIDTH + 2;
  endfunction

  // Count edges until done; optionally pokes start/hi_we at cycle 10 of the op
  task automatic waitDone(input bit interfere, output int n, output int busyCnt);
    n = 1; busyCnt = 0;
    while (!done && n < 60) begin
      if (busy) busyCnt++;
      if (interfere && n == 10) begin
        start = 1'b1; op = 2'b11; a = $urandom; b = $urandom;
        hi_we = 1'b1; wdata = 32'h5555_AAAA;
      end
      if (interfere && n == 11) begin
        start = 1'b0; hi_we = 1'b0;
      end
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic checkResult(input string tag, input logic [1:0] o, input logic [31:0] x,
                             input logic [31:0] y, input int n, input int busyCnt);
    logic [31:0] eh, el;
    int lat;
    refModel(o, x, y, eh, el);
    lat = expLat(o, x, y);
    checkOutput({tag, ":done"}, 64'(done), 64'd1);
    checkOutput({tag, ":latency"}, 64'(n), 64'(lat));
    checkOutput({tag, ":busyCycles"}, 64'(busyCnt), 64'(lat - 1));
    checkOutput({tag, ":busyAtDone"}, 64'(busy), 64'd0);
    checkOutput({tag, ":hi"}, 64'(hi), 64'(eh));
    checkOutput({tag, ":lo"}, 64'(lo), 64'(el));
    modelHi = eh; modelLo = el;
  endtask

  // Issue one operation from IDLE and verify latency, busy window and HI/LO
  task automatic applyStimulus(input string tag, input logic [1:0] o, input logic [31:0] x,
                               input logic [31:0] y, input bit interfere, input bit mtWith);
    int n, busyCnt;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    if (mtWith) begin hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF; end
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    waitDone(interfere, n, busyCnt);
    checkResult(tag, o, x, y, n, busyCnt);
    @(posedge clk); #1;
    checkOutput({tag, ":donePulse"}, 64'(done), 64'd0);
  endtask

  // Second op started in the done cycle of the first
  task automatic backToBack(input logic [1:0] o1, input logic [31:0] x1, input logic [31:0] y1,
                            input logic [1:0] o2, input logic [31:0] x2, input logic [31:0] y2);
    int n, busyCnt;
    @(negedge clk);
    op = o1; a = x1; b = y1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    waitDone(1'b0, n, busyCnt);
    checkResult("b2b_first", o1, x1, y1, n, busyCnt);
    op = o2; a = x2; b = y2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    checkOutput("b2b_accepted", 64'(busy), 64'd1);
    waitDone(1'b0, n, busyCnt);
    checkResult("b2b_second", o2, x2, y2, n, busyCnt);
    @(posedge clk); #1;
  endtask

  // MTHI/MTLO writes in IDLE: registers update at the next edge with no done
  task automatic mtWrite(input string tag, input bit wh, input bit wl, input logic [31:0] d);
    @(negedge clk);
    hi_we = wh; lo_we = wl; wdata = d;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    if (wh) modelHi = d;
    if (wl) modelLo = d;
    checkOutput({tag, ":hi"}, 64'(hi), 64'(modelHi));
    checkOutput({tag, ":lo"}, 64'(lo), 64'(modelLo));
    checkOutput({tag, ":noDone"}, 64'(done), 64'd0);
  endtask

  // Asynchronous reset in the middle of a DIV aborts it silently
  task automatic resetMidOp();
    bit sawDone;
    @(negedge clk);
    op = 2'b10; a = 32'h0BAD_F00D; b = 32'd13; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (14) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("rstMid:busy", 64'(busy), 64'd0);
    checkOutput("rstMid:hi", 64'(hi), 64'd0);
    checkOutput("rstMid:lo", 64'(lo), 64'd0);
    checkOutput("rstMid:done", 64'(done), 64'd0);
    #1 rst = 1'b0;
    modelHi = '0; modelLo = '0;
    sawDone = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) sawDone = 1'b1;
    end
    checkOutput("rstMid:noDoneAfter", 64'(sawDone), 64'd0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] rx, ry;
    rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    #12;
    checkOutput("reset:busy", 64'(busy), 64'd0);
    checkOutput("reset:done", 64'(done), 64'd0);
    checkOutput("reset:hi", 64'(hi), 64'd0);
    checkOutput("reset:lo", 64'(lo), 64'd0);
    @(negedge clk); rst = 1'b0;

    applyStimulus("mult_neg3x5",   2'b00, 32'hFFFF_FFFD, 32'd5,         1'b0, 1'b0);
    applyStimulus("multu_allones", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    applyStimulus("mult_allones",  2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    applyStimulus("div_neg7by2",   2'b10, 32'hFFFF_FFF9, 32'd2,         1'b0, 1'b0);
    applyStimulus("divu_100by7",   2'b11, 32'd100,       32'd7,         1'b0, 1'b0);
    applyStimulus("div_minbyneg1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    applyStimulus("divu_byzero",   2'b11, 32'h0000_1234, 32'd0,         1'b0, 1'b0);
    applyStimulus("div_negbyzero", 2'b10, 32'hFFFF_FFF9, 32'd0,         1'b0, 1'b0);
    applyStimulus("mult_zero",     2'b00, 32'd0,         32'h1234_5678, 1'b0, 1'b0);
    applyStimulus("mult_interf",   2'b00, 32'h0001_2345, 32'hFFFF_0003, 1'b1, 1'b0);
    applyStimulus("start_vs_mt",   2'b01, 32'h0000_0007, 32'h0000_0009, 1'b0, 1'b1);

    mtWrite("mtlo", 1'b0, 1'b1, 32'hA5A5_A5A5);
    mtWrite("mthi", 1'b1, 1'b0, 32'h3C3C_3C3C);
    mtWrite("mtboth", 1'b1, 1'b1, 32'h0F0F_1234);

    backToBack(2'b11, 32'd1000, 32'd33, 2'b00, 32'hFFFF_FF00, 32'h0000_0100);

    resetMidOp();
    applyStimulus("after_reset", 2'b10, 32'd12345, 32'hFFFF_FFF0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      if ($urandom_range(0, 3) == 0) ry = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) rx = 32'd0;
      applyStimulus($sformatf("rand%0d", i), ro, rx, ry, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
